multicycle_control: RTL and testbench

Multi-cycle sequencer that replaces the single-cycle opcode decoder for the shared-memory CPU datapath. It steps each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states and drives the datapath mux selects and write strobes. It stalls on a memory-ready handshake and counts retired instructions. On an illegal opcode or a memory timeout it halts with an error code.

---
 rtl/multicycle_control_if.sv | 38 +++
 rtl/multicycle_control.sv | 216 +++++++++++++++++++++
 tb/tb_multicycle_control.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Control bus between the multi-cycle sequencer and the shared-memory CPU datapath.
// The controller drives the master side; the datapath and memory drive the slave side.
interface multicycle_control_if #(
  parameter int CNT_W = 16
);
  logic [5:0]       Op;
  logic             Zero;
  logic             mem_ready;
  logic             PCWrite;
  logic             IRWrite;
  logic             IorD;
  logic             MemRead;
  logic             MemWrite;
  logic             MemtoReg;
  logic             RegDst;
  logic             RegWrite;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [2:0]       ALUOp;
  logic [1:0]       PCSource;
  logic             halted;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  Op, Zero, mem_ready,
    output PCWrite, IRWrite, IorD, MemRead, MemWrite, MemtoReg, RegDst,
           RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, halted, err_code,
           instr_count
  );

  modport slave (
    output Op, Zero, mem_ready,
    input  PCWrite, IRWrite, IorD, MemRead, MemWrite, MemtoReg, RegDst,
           RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, halted, err_code,
           instr_count
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle instruction sequencer: steps FETCH..WRITEBACK, stalls on mem_ready,
// counts retired instructions and halts with an error code on bad opcode or memory timeout.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input logic                  clk,
  input logic                  rst,
  multicycle_control_if.master bus
);

  localparam int WW = $clog2(MEM_TIMEOUT);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

  localparam logic [5:0] OP_LW   = 6'd35;
  localparam logic [5:0] OP_SW   = 6'd43;
  localparam logic [5:0] OP_R    = 6'd20;
  localparam logic [5:0] OP_ADDI = 6'd8;
  localparam logic [5:0] OP_SUBI = 6'd9;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_J    = 6'd2;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_LWWB, S_MEMWR,
    S_EXEC_R, S_RWB, S_EXEC_I, S_IWB, S_BRANCH, S_JUMP, S_HALT
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_ILLEGAL = 2'b01,
    ERR_TIMEOUT = 2'b10
  } err_e;

  state_e           state_q, state_d;
  err_e             err_q, err_d;
  logic [5:0]       op_q, op_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_stall;

  logic       pc_write, ir_write, iord, mem_read, mem_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, halted;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      err_q   <= ERR_NONE;
      op_q    <= '0;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    op_d      = op_q;
    wait_d    = wait_q;
    cnt_d     = cnt_q;
    mem_stall = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        if (bus.mem_ready) state_d = S_DECODE;
        else               mem_stall = 1'b1;
      end
      S_DECODE: begin
        op_d = bus.Op;
        unique case (bus.Op)
          OP_LW, OP_SW:     state_d = S_MEMADR;
          OP_R:             state_d = S_EXEC_R;
          OP_ADDI, OP_SUBI: state_d = S_EXEC_I;
          OP_BEQ:           state_d = S_BRANCH;
          OP_J:             state_d = S_JUMP;
          default: begin
            state_d = S_HALT;
            err_d   = ERR_ILLEGAL;
          end
        endcase
      end
      S_MEMADR: state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (bus.mem_ready) state_d = S_LWWB;
        else               mem_stall = 1'b1;
      end
      S_LWWB:   state_d = S_FETCH;
      S_MEMWR: begin
        if (bus.mem_ready) state_d = S_FETCH;
        else               mem_stall = 1'b1;
      end
      S_EXEC_R: state_d = S_RWB;
      S_RWB:    state_d = S_FETCH;
      S_EXEC_I: state_d = S_IWB;
      S_IWB:    state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_HALT;
    endcase

    // A ready on the last allowed wait cycle completes normally; only a stall times out.
    if (mem_stall) begin
      if (wait_q == WAIT_LAST) begin
        state_d = S_HALT;
        err_d   = ERR_TIMEOUT;
      end else begin
        wait_d = wait_q + 1'b1;
      end
    end
    if (state_d != state_q) wait_d = '0;

    // Only retiring states ever move into FETCH, so any entry from elsewhere retires one.
    if (state_q != S_FETCH && state_d == S_FETCH) cnt_d = cnt_q + 1'b1;
  end

  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 3'b000;
    pc_source  = 2'b00;
    halted     = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = bus.mem_ready;
        pc_write  = bus.mem_ready;
      end
      S_DECODE: alu_src_b = 2'b11;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_LWWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b010;
      end
      S_RWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = (op_q == OP_SUBI) ? 3'b001 : 3'b000;
      end
      S_IWB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b101;
        pc_source = 2'b01;
        pc_write  = bus.Zero;
      end
      S_JUMP: begin
        pc_source = 2'b10;
        pc_write  = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      default: halted = 1'b1;
    endcase

    if (rst) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
    end
  end

  assign bus.PCWrite     = pc_write;
  assign bus.IRWrite     = ir_write;
  assign bus.IorD        = iord;
  assign bus.MemRead     = mem_read;
  assign bus.MemWrite    = mem_write;
  assign bus.MemtoReg    = mem_to_reg;
  assign bus.RegDst      = reg_dst;
  assign bus.RegWrite    = reg_write;
  assign bus.ALUSrcA     = alu_src_a;
  assign bus.ALUSrcB     = alu_src_b;
  assign bus.ALUOp       = alu_op;
  assign bus.PCSource    = pc_source;
  assign bus.halted      = halted;
  assign bus.err_code    = err_q;
  assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle control-word checks against hand-built
// expected words, plus retired-count, halt and error-code checks.
module tb_multicycle_control;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  multicycle_control_if #(.CNT_W(16)) bus ();

  multicycle_control #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // {PCWrite,IRWrite,IorD,MemRead,MemWrite,MemtoReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource,halted,err_code}
  function automatic logic [18:0] mk(input logic pcw, input logic irw, input logic iord,
                                     input logic mr, input logic mw, input logic m2r,
                                     input logic rd, input logic rw, input logic sa,
                                     input logic [1:0] sb, input logic [2:0] aop,
                                     input logic [1:0] pcs, input logic h, input logic [1:0] e);
    return {pcw, irw, iord, mr, mw, m2r, rd, rw, sa, sb, aop, pcs, h, e};
  endfunction

  function automatic logic [18:0] obs_word();
    return {bus.PCWrite, bus.IRWrite, bus.IorD, bus.MemRead, bus.MemWrite, bus.MemtoReg,
            bus.RegDst, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCSource,
            bus.halted, bus.err_code};
  endfunction

  logic [18:0] W_RST, W_F, W_FW, W_DEC, W_MADR, W_MRD, W_LWWB, W_MWR, W_MWR_RST;
  logic [18:0] W_EXR, W_RWB, W_EXADD, W_EXSUB, W_IWB, W_BRZ, W_BRNZ, W_JMP;
  logic [18:0] W_HALT_ILL, W_HALT_TO;

  task automatic check_word(input string tag, input logic [18:0] exp);
    logic [18:0] o;
    o = obs_word();
    total++;
    assert (o === exp) else begin
      fails++;
      $error("FAIL %s: ctrl word got %b expected %b", tag, o, exp);
    end
  endtask

  task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
    total++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive inputs, check the control word mid-cycle, then advance past the next rising edge.
  task automatic cyc(input string tag, input logic [5:0] op, input logic z, input logic rdy,
                     input logic r, input logic [18:0] exp);
    rst           = r;
    bus.Op        = op;
    bus.Zero      = z;
    bus.mem_ready = rdy;
    #1;
    check_word(tag, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    W_RST      = mk(0,0,0,0,0,0,0,0,0,2'b01,3'b000,2'b00,0,2'b00);
    W_F        = mk(1,1,0,1,0,0,0,0,0,2'b01,3'b000,2'b00,0,2'b00);
    W_FW       = mk(0,0,0,1,0,0,0,0,0,2'b01,3'b000,2'b00,0,2'b00);
    W_DEC      = mk(0,0,0,0,0,0,0,0,0,2'b11,3'b000,2'b00,0,2'b00);
    W_MADR     = mk(0,0,0,0,0,0,0,0,1,2'b10,3'b000,2'b00,0,2'b00);
    W_MRD      = mk(0,0,1,1,0,0,0,0,0,2'b00,3'b000,2'b00,0,2'b00);
    W_LWWB     = mk(0,0,0,0,0,1,0,1,0,2'b00,3'b000,2'b00,0,2'b00);
    W_MWR      = mk(0,0,1,0,1,0,0,0,0,2'b00,3'b000,2'b00,0,2'b00);
    W_MWR_RST  = mk(0,0,1,0,0,0,0,0,0,2'b00,3'b000,2'b00,0,2'b00);
    W_EXR      = mk(0,0,0,0,0,0,0,0,1,2'b00,3'b010,2'b00,0,2'b00);
    W_RWB      = mk(0,0,0,0,0,0,1,1,0,2'b00,3'b000,2'b00,0,2'b00);
    W_EXADD    = mk(0,0,0,0,0,0,0,0,1,2'b10,3'b000,2'b00,0,2'b00);
    W_EXSUB    = mk(0,0,0,0,0,0,0,0,1,2'b10,3'b001,2'b00,0,2'b00);
    W_IWB      = mk(0,0,0,0,0,0,0,1,0,2'b00,3'b000,2'b00,0,2'b00);
    W_BRZ      = mk(1,0,0,0,0,0,0,0,1,2'b00,3'b101,2'b01,0,2'b00);
    W_BRNZ     = mk(0,0,0,0,0,0,0,0,1,2'b00,3'b101,2'b01,0,2'b00);
    W_JMP      = mk(1,0,0,0,0,0,0,0,0,2'b00,3'b000,2'b10,0,2'b00);
    W_HALT_ILL = mk(0,0,0,0,0,0,0,0,0,2'b00,3'b000,2'b00,1,2'b01);
    W_HALT_TO  = mk(0,0,0,0,0,0,0,0,0,2'b00,3'b000,2'b00,1,2'b10);

    bus.Op = '0; bus.Zero = 1'b0; bus.mem_ready = 1'b1;
    @(posedge clk); #1;

    // Reset state: FETCH with strobes suppressed while rst is high.
    check_word("reset_word", W_RST);
    check_val("reset_count", bus.instr_count, 0);
    @(posedge clk); #1;

    // addi, R-type, LW, SW, J with memory always ready.
    cyc("addi_F", 6'd8, 0, 1, 0, W_F);     cyc("addi_D", 6'd8, 0, 1, 0, W_DEC);
    cyc("addi_X", 6'd8, 0, 1, 0, W_EXADD); cyc("addi_WB", 6'd8, 0, 1, 0, W_IWB);
    check_val("count_addi", bus.instr_count, 1);
    cyc("r_F", 6'd20, 0, 1, 0, W_F);       cyc("r_D", 6'd20, 0, 1, 0, W_DEC);
    cyc("r_X", 6'd20, 0, 1, 0, W_EXR);     cyc("r_WB", 6'd20, 0, 1, 0, W_RWB);
    cyc("lw_F", 6'd35, 0, 1, 0, W_F);      cyc("lw_D", 6'd35, 0, 1, 0, W_DEC);
    cyc("lw_A", 6'd35, 0, 1, 0, W_MADR);   cyc("lw_M", 6'd35, 0, 1, 0, W_MRD);
    cyc("lw_WB", 6'd35, 0, 1, 0, W_LWWB);
    cyc("sw_F", 6'd43, 0, 1, 0, W_F);      cyc("sw_D", 6'd43, 0, 1, 0, W_DEC);
    cyc("sw_A", 6'd43, 0, 1, 0, W_MADR);   cyc("sw_M", 6'd43, 0, 1, 0, W_MWR);
    cyc("j_F", 6'd2, 0, 1, 0, W_F);        cyc("j_D", 6'd2, 0, 1, 0, W_DEC);
    cyc("j_J", 6'd2, 0, 1, 0, W_JMP);
    check_val("count_prog", bus.instr_count, 5);

    // BEQ taken and not taken.
    cyc("beq1_F", 6'd4, 1, 1, 0, W_F);     cyc("beq1_D", 6'd4, 1, 1, 0, W_DEC);
    cyc("beq1_B", 6'd4, 1, 1, 0, W_BRZ);
    cyc("beq0_F", 6'd4, 0, 1, 0, W_F);     cyc("beq0_D", 6'd4, 0, 1, 0, W_DEC);
    cyc("beq0_B", 6'd4, 0, 1, 0, W_BRNZ);
    check_val("count_beq", bus.instr_count, 7);

    // subi selects ALU subtract.
    cyc("subi_F", 6'd9, 0, 1, 0, W_F);     cyc("subi_D", 6'd9, 0, 1, 0, W_DEC);
    cyc("subi_X", 6'd9, 0, 1, 0, W_EXSUB); cyc("subi_WB", 6'd9, 0, 1, 0, W_IWB);

    // LW stalled 3 cycles; ready arrives on the last allowed wait cycle.
    cyc("lws_F", 6'd35, 0, 1, 0, W_F);     cyc("lws_D", 6'd35, 0, 1, 0, W_DEC);
    cyc("lws_A", 6'd35, 0, 1, 0, W_MADR);
    cyc("lws_M0", 6'd35, 0, 0, 0, W_MRD);  cyc("lws_M1", 6'd35, 0, 0, 0, W_MRD);
    cyc("lws_M2", 6'd35, 0, 0, 0, W_MRD);  cyc("lws_M3", 6'd35, 0, 1, 0, W_MRD);
    cyc("lws_WB", 6'd35, 0, 1, 0, W_LWWB);
    check_val("count_lws", bus.instr_count, 9);

    // FETCH timeout: 4 waiting cycles then HALT with err 10, count frozen.
    cyc("fto_0", 6'd0, 0, 0, 0, W_FW);     cyc("fto_1", 6'd0, 0, 0, 0, W_FW);
    cyc("fto_2", 6'd0, 0, 0, 0, W_FW);     cyc("fto_3", 6'd0, 0, 0, 0, W_FW);
    cyc("fto_H0", 6'd0, 0, 1, 0, W_HALT_TO);
    cyc("fto_H1", 6'd8, 1, 1, 0, W_HALT_TO);
    check_val("count_fto", bus.instr_count, 9);

    // One-cycle reset out of HALT.
    cyc("rst1", 6'd0, 0, 1, 1, W_HALT_TO);
    check_val("rst1_count", bus.instr_count, 0);
    check_val("rst1_err", bus.err_code, 0);

    // Illegal opcode.
    cyc("ill_F", 6'd63, 0, 1, 0, W_F);     cyc("ill_D", 6'd63, 0, 1, 0, W_DEC);
    cyc("ill_H", 6'd63, 0, 1, 0, W_HALT_ILL);
    check_val("ill_count", bus.instr_count, 0);
    cyc("rst2", 6'd0, 0, 1, 1, W_HALT_ILL);
    check_val("rst2_err", bus.err_code, 0);

    // Reset during MEMWR abandons the store.
    cyc("a2_F", 6'd8, 0, 1, 0, W_F);       cyc("a2_D", 6'd8, 0, 1, 0, W_DEC);
    cyc("a2_X", 6'd8, 0, 1, 0, W_EXADD);   cyc("a2_WB", 6'd8, 0, 1, 0, W_IWB);
    check_val("a2_count", bus.instr_count, 1);
    cyc("swr_F", 6'd43, 0, 1, 0, W_F);     cyc("swr_D", 6'd43, 0, 1, 0, W_DEC);
    cyc("swr_A", 6'd43, 0, 1, 0, W_MADR);  cyc("swr_M", 6'd43, 0, 1, 1, W_MWR_RST);
    cyc("swr_F2", 6'd0, 0, 1, 0, W_F);
    check_val("swr_count", bus.instr_count, 0);

    // MEMWR timeout.
    cyc("swt_D", 6'd43, 0, 1, 0, W_DEC);   cyc("swt_A", 6'd43, 0, 1, 0, W_MADR);
    cyc("swt_M0", 6'd43, 0, 0, 0, W_MWR);  cyc("swt_M1", 6'd43, 0, 0, 0, W_MWR);
    cyc("swt_M2", 6'd43, 0, 0, 0, W_MWR);  cyc("swt_M3", 6'd43, 0, 0, 0, W_MWR);
    cyc("swt_H", 6'd43, 0, 1, 0, W_HALT_TO);
    check_val("swt_count", bus.instr_count, 0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
